// File: rtl/mem_responder.sv
// mem_responder: AXI4-Lite-style memory slave with a programmable fixed
// response latency. One read channel (AR/R) and one write channel (AW/W/B)
// operate independently against a word-addressed backing array. Each channel
// holds at most one outstanding transaction and all outputs are registered.
module mem_responder #(
    parameter int unsigned DEPTH = 16384,
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,

    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IW     = $clog2(DEPTH);
    localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
    localparam logic [7:0]  LAT_LD = 8'(LAT);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t    r_state;
    logic [7:0]  r_cnt;
    logic [31:0] ar_addr;

    w_state_t    w_state;
    logic [7:0]  w_cnt;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    // Address decode. The offset wraps for addresses below BASE, so a single
    // unsigned compare of the full offset covers both ends of the window.
    logic [31:0]   ar_off;
    logic          ar_ok;
    logic [IW-1:0] ar_idx;
    logic [31:0]   aw_off;
    logic          aw_ok;
    logic [IW-1:0] aw_idx;

    assign ar_off = ar_addr - BASE;
    assign ar_ok  = {1'b0, ar_off} < SPAN;
    assign ar_idx = ar_off[IW+1:2];

    assign aw_off = aw_addr - BASE;
    assign aw_ok  = {1'b0, aw_off} < SPAN;
    assign aw_idx = aw_off[IW+1:2];

    // In W_IDLE a low ready means that beat is already held.
    logic aw_got;
    logic w_got;
    logic commit;

    assign aw_got = !awready || awvalid;
    assign w_got  = !wready  || wvalid;
    assign commit = (w_state == W_WAIT) && (w_cnt == 8'd0) && aw_ok;

    // Read channel: accept, count down the latency, then present the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= 8'd0;
            ar_addr <= 32'd0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_addr <= araddr;
                        r_cnt   <= LAT_LD;
                        arready <= 1'b0;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        // Sampled with the pre-edge array contents, so a write
                        // committing on this same edge is not yet visible.
                        if (ar_ok) begin
                            rdata <= mem[ar_idx];
                            rresp <= OKAY;
                        end else begin
                            rdata <= 32'd0;
                            rresp <= SLVERR;
                        end
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    arready <= 1'b1;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Write channel: collect AW and W in any order, wait out the latency,
    // commit, then hold the B response until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_cnt   <= 8'd0;
            aw_addr <= 32'd0;
            w_data  <= 32'd0;
            w_strb  <= 4'd0;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        aw_addr <= awaddr;
                        awready <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        wready <= 1'b0;
                    end
                    if (aw_got && w_got) begin
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        w_cnt   <= LAT_LD;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 8'd0) begin
                        bresp   <= aw_ok ? OKAY : SLVERR;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 8'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    awready <= 1'b1;
                    wready  <= 1'b1;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Backing array: byte-strobed write on the commit edge; never reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven directed vectors, hand-written corner-case
// sequences (split channels, backpressure, collision, async reset) and a
// randomized run checked against a behavioural memory model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    mem_responder #(
        .DEPTH (DEPTH),
        .BASE  (BASE),
        .LAT   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    int unsigned ref_mem [int];

    function automatic bit ref_ok(input logic [31:0] a);
        longint d;
        d = a;
        d = d - longint'(BASE);
        return (d >= 0) && (d < 4 * longint'(DEPTH));
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        longint d;
        d = a;
        d = d - longint'(BASE);
        return int'(d / 4);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned v;
        int unsigned m;
        if (!ref_ok(a)) return;
        v = ref_mem.exists(ref_idx(a)) ? ref_mem[ref_idx(a)] : 0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                m = 32'hFF << (8 * b);
                v = (v & ~m) | (d & m);
            end
        end
        ref_mem[ref_idx(a)] = v;
    endtask

    // ---------------- bus driver tasks ----------------
    // All tasks start and end at #1 after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int skew, input int hold, output logic [1:0] r);
        bit aw_done, w_done, aw_hs, w_hs;
        int aw_start, w_start, cyc, k;
        logic [1:0] r0;
        aw_done = 0; w_done = 0; r = 2'b11;
        aw_start = (skew > 0) ? skew : 0;
        w_start  = (skew < 0) ? -skew : 0;
        awaddr = a; wdata = d; wstrb = s;
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 60) begin
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            if (aw_hs && !w_done) chk("awready_drop", 32'(awready), 32'd0);
            if (w_hs && !aw_done) chk("wready_drop", 32'(wready), 32'd0);
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            chk("w_accept_timeout", 32'd0, 32'd1);
            return;
        end
        chk("aw_w_ready_busy", 32'({awready, wready}), 32'd0);
        k = 0;
        while (!bvalid && k < int'(LAT) + 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b_latency", 32'(k), 32'(LAT + 1));
        r0 = bresp;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("b_hold", 32'({bvalid, bresp}), 32'({1'b1, r0}));
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        chk("b_release", 32'({bvalid, awready, wready}), 32'b011);
        r = r0;
    endtask

    task automatic do_read(input logic [31:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] r);
        int k;
        logic [31:0] d0;
        logic [1:0]  r0;
        d = 32'hX; r = 2'b11;
        araddr = a; arvalid = 1;
        k = 0;
        while (!arready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!arready) begin
            arvalid = 0;
            chk("ar_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk); #1;
        arvalid = 0;
        chk("arready_busy", 32'(arready), 32'd0);
        k = 0;
        while (!rvalid && k < int'(LAT) + 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("r_latency", 32'(k), 32'(LAT + 1));
        d0 = rdata; r0 = rresp;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("r_hold_data", rdata, d0);
            chk("r_hold_ctl", 32'({rvalid, arready, rresp}), 32'({1'b1, 1'b0, r0}));
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        chk("r_release", 32'({rvalid, arready}), 32'b01);
        d = d0; r = r0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [16];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] a;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          k;

        vt[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'h0};
        vt[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 2'b00, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 2'b00, 32'h0};
        vt[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0};
        vt[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'b0000, 2'b00, 32'h11BB_33DD};
        vt[5]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'h0};
        vt[6]  = '{1'b0, 32'h8000_0022, 32'h0,         4'b0000, 2'b00, 32'h11BB_33DD};
        vt[7]  = '{1'b1, 32'h8000_0000, 32'h0BAD_C0DE, 4'b1111, 2'b00, 32'h0};
        vt[8]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'b1111, 2'b10, 32'h0};
        vt[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'b0000, 2'b00, 32'h0BAD_C0DE};
        vt[10] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 2'b10, 32'h0};
        vt[11] = '{1'b0, 32'h8000_1000, 32'h0,         4'b0000, 2'b10, 32'h0};
        vt[12] = '{1'b1, 32'h8000_0FFF, 32'hCAFE_F00D, 4'b1111, 2'b00, 32'h0};
        vt[13] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'b0000, 2'b00, 32'hCAFE_F00D};
        vt[14] = '{1'b1, 32'h7FFF_FFFC, 32'h0000_0001, 4'b1111, 2'b10, 32'h0};
        vt[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 2'b10, 32'h0};

        rst = 1; araddr = 0; arvalid = 0; rready = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;

        // reset values while rst is held
        #12;
        chk("rst_ready", 32'({arready, awready, wready}), 32'b111);
        chk("rst_valid", 32'({rvalid, bvalid}), 32'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", 32'({rresp, bresp}), 32'h0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // table-driven vectors, all channels aligned
        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, r);
                chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vt[i].exp_resp));
                ref_write(vt[i].addr, vt[i].data, vt[i].strb);
            end else begin
                do_read(vt[i].addr, 0, d, r);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].exp_resp));
                chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
            end
        end

        // split channels: W four cycles ahead of AW, then AW ahead of W
        do_write(32'h8000_0040, 32'h0102_0304, 4'b1111, 4, 0, r);
        chk("split_w_first_bresp", 32'(r), 32'd0);
        ref_write(32'h8000_0040, 32'h0102_0304, 4'b1111);
        do_write(32'h8000_0044, 32'h0506_0708, 4'b1100, -3, 2, r);
        chk("split_aw_first_bresp", 32'(r), 32'd0);
        ref_write(32'h8000_0044, 32'h0506_0708, 4'b1100);

        // read backpressure for five cycles
        do_read(32'h8000_0040, 5, d, r);
        chk("bp_rdata", d, 32'h0102_0304);
        chk("bp_rresp", 32'(r), 32'd0);

        // collision: read and write of the same word accepted on one edge
        do_write(32'h8000_0080, 32'h5555_5555, 4'b1111, 0, 0, r);
        ref_write(32'h8000_0080, 32'h5555_5555, 4'b1111);
        chk("coll_idle", 32'({arready, awready, wready}), 32'b111);
        araddr = 32'h8000_0080; arvalid = 1;
        awaddr = 32'h8000_0080; wdata = 32'hA5A5_0F0F; wstrb = 4'b1111;
        awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        arvalid = 0; awvalid = 0; wvalid = 0;
        k = 0;
        while (!rvalid && k < int'(LAT) + 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("coll_r_latency", 32'(k), 32'(LAT + 1));
        chk("coll_bvalid", 32'(bvalid), 32'd1);
        chk("coll_old_data", rdata, 32'h5555_5555);
        rready = 1; bready = 1;
        @(posedge clk); #1;
        rready = 0; bready = 0;
        ref_write(32'h8000_0080, 32'hA5A5_0F0F, 4'b1111);
        do_read(32'h8000_0080, 0, d, r);
        chk("coll_new_data", d, 32'hA5A5_0F0F);

        // async reset mid-transaction: pending response and uncommitted write
        araddr = 32'h8000_0010; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        k = 0;
        while (!rvalid && k < int'(LAT) + 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rstmid_pre_rdata", rdata, 32'hDEAD_BEEF);
        awaddr = 32'h8000_0010; wdata = 32'h0; wstrb = 4'b1111;
        awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        #2;
        rst = 1;
        #1;
        chk("rstmid_valid", 32'({rvalid, bvalid}), 32'b00);
        chk("rstmid_ready", 32'({arready, awready, wready}), 32'b111);
        chk("rstmid_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        do_read(32'h8000_0010, 0, d, r);
        chk("rstmid_write_dropped", d, 32'hDEAD_BEEF);

        // randomized run against the reference model
        for (int w = 0; w < 16; w++) begin
            a = BASE + 32'(4 * w);
            d = $urandom;
            do_write(a, d, 4'b1111, 0, 0, r);
            ref_write(a, d, 4'b1111);
        end
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE - 32'(4 * $urandom_range(1, 8));
                1:       a = TOP + 32'($urandom_range(0, 64));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            exp_r = ref_ok(a) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wstrb = 4'($urandom_range(0, 15));
                do_write(a, d, wstrb, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), r);
                chk("rand_bresp", 32'(r), 32'(exp_r));
                ref_write(a, d, wstrb);
            end else begin
                exp_d = ref_ok(a) ? ref_mem[ref_idx(a)] : 32'h0;
                do_read(a, int'($urandom_range(0, 2)), d, r);
                chk("rand_rresp", 32'(r), 32'(exp_r));
                chk("rand_rdata", d, exp_d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's instruction-fetch and load/store request interfaces. It is an AXI4-Lite-style slave with one read channel (AR/R) and one write channel (AW/W/B), backed by an internal word-addressed array. It adds a programmable fixed response latency so pipeline stalls in the fetch and memory stages can be exercised. One instance serves one requester; fetch and LSU each get their own.

## Interface
Parameters:
- DEPTH, 16384: number of 32-bit words in the backing array; must be a power of two.
- BASE, 32'h8000_0000: byte address of word 0.
- LAT, 2: extra wait cycles between request acceptance and response; 0–255.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- araddr  in  32  read byte address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rdata  out  32  read data; the full word, byte lanes are not shifted.
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read response valid.
- rready  in  1  requester accepts read response.
- awaddr  in  32  write byte address.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte enables; wstrb[i] writes byte lane i (bits 8i+7:8i).
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response; same encoding as rresp.
- bvalid / bready  out / in  1  write-response handshake.

## Operation
- Address decode: addr is in range iff BASE ≤ addr < BASE+4·DEPTH. Word index = (addr−BASE)[log2(DEPTH)+1:2]. Address bits [1:0] are ignored.
- Read FSM: R_IDLE → R_WAIT → R_RESP → R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, capture araddr and load the counter with LAT.
  - R_WAIT: arready=0. Decrement the counter each cycle. When the counter is 0, on that edge latch rdata/rresp from the array and go to R_RESP.
  - R_RESP: rvalid=1; rdata/rresp are held stable until rvalid&rready. On that handshake, go to R_IDLE.
- Write FSM: W_IDLE → W_WAIT → W_RESP → W_IDLE.
  - W_IDLE: awready=1 until the AW beat is captured; wready=1 until the W beat is captured. AW and W may arrive in either order or in the same cycle.
  - Once both beats are held, go to W_WAIT with the counter loaded with LAT. awready=wready=0 outside W_IDLE and for any channel already captured.
  - W_WAIT end: on the edge where the counter is 0, commit the strobed bytes to the array (in-range only) and go to W_RESP.
  - W_RESP: bvalid=1 until bvalid&bready, then go to W_IDLE.
- Out of range: rresp=2'b10 with rdata=32'h0; bresp=2'b10 with the array untouched.
- Read and write are independent: at most one outstanding read and one outstanding write.
- Read/write collision on the same word at the same edge: the read latches the old data; the write is visible from the next cycle.
- wstrb=4'b0000: bresp=OKAY, array unchanged.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; both FSMs in IDLE; counters 0.
- The array is not reset. Asserting rst mid-transaction drops the transaction immediately (asynchronously); an in-flight write that has not yet committed is not applied.
- Read latency: AR handshake at edge T gives rvalid high after edge T+1+LAT. With LAT=0, rvalid is high one cycle after acceptance.
- Read throughput: the next AR handshake is possible at the edge after the R handshake. Back-to-back reads with rready held high therefore take LAT+3 cycles each.
- Write latency: the later of the AW/W captures at edge T gives the array write and bvalid rising together at edge T+1+LAT.
- All outputs are registered. No combinational path exists from any input to any output.
- Handshake stability: rvalid and bvalid never drop before their ready is seen. rdata, rresp and bresp do not change while their valid is high.

## Test plan
- Reset then idle: rst pulse mid-cycle → all outputs take their reset values immediately; arready=awready=wready=1.
- Write then read, LAT=2:
  - AW 0x8000_0010 and W 0xDEAD_BEEF/4'b1111 in the same cycle (edge T) → bvalid at T+3, bresp=0.
  - Then AR 0x8000_0010 → rvalid 3 cycles after acceptance with rdata=0xDEAD_BEEF.
- Byte strobe: word holds 0x1122_3344; write 0xAABB_CCDD with wstrb=4'b0101 → read returns 0x11BB_33DD.
- Split channels and backpressure:
  - W beat 4 cycles before AW → wready drops after the W capture; bvalid comes LAT+1 after the AW capture.
  - Hold rready=0 for 5 cycles → rvalid and rdata stay stable; arready stays 0.
- Out of range: AR 0x7FFF_FFFC → rresp=2'b10, rdata=0. Write to BASE+4·DEPTH → bresp=2'b10; word 0 is unchanged on readback.
- Collision, LAT=0: read and write to the same word commit on the same edge → the read returns the old value; a following read returns the new value.
